instruction_memory: RTL and testbench

- Word-organised instruction store for the 5-stage MIPS pipeline, read by the IF stage.
- Byte address from the PC mux selects a 32-bit instruction, returned combinationally in the same cycle.
- Holds a built-in default program, loaded at power-up and on every reset; a synchronous program-load port can overwrite words.

---
 rtl/instruction_memory.sv | 69 ++++++
 tb/tb_instruction_memory.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// Word-organised instruction store for the IF stage, with built-in default program and program-load port.
// Define IMEM_FAULT_EN to add the combinational `fault` output (misaligned or out-of-range pc).
module instruction_memory #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_wdata,
    output logic [31:0]       instruction
`ifdef IMEM_FAULT_EN
    ,
    output logic              fault
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    localparam logic [31:0] DEFAULT_IMAGE [DEPTH] = '{
        0: 32'h20080005,
        1: 32'h2009000A,
        2: 32'h01095020,
        3: 32'h01285822,
        4: 32'hAC0A0000,
        5: 32'h8C0C0000,
        6: 32'h08000000,
        default: 32'h00000000
    };

    // The declaration value gives the default program at power-up, before any reset.
    logic [31:0] mem_q [DEPTH] = DEFAULT_IMAGE;
    logic [31:0] mem_d [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_in_range;
    logic             wr_in_range;

    assign rd_idx      = pc[IDX_W+1:2];
    assign wr_idx      = prog_addr[IDX_W+1:2];
    assign rd_in_range = (pc[ADDR_W-1:IDX_W+2] == '0);
    assign wr_in_range = (prog_addr[ADDR_W-1:IDX_W+2] == '0);

    always_comb begin
        mem_d = mem_q;
        if (reset) begin
            mem_d = DEFAULT_IMAGE;
        end else if (prog_we && wr_in_range) begin
            mem_d[wr_idx] = prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign instruction = rd_in_range ? mem_q[rd_idx] : '0;

`ifdef IMEM_FAULT_EN
    assign fault = (pc[1:0] != 2'b00) || !rd_in_range;
`endif

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{pc[1:0], prog_addr[1:0]};

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory (default image, reads, loads, reset, boundaries).
module tb_instruction_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;
    logic [31:0] instruction;
`ifdef IMEM_FAULT_EN
    logic        fault;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] image [8] = '{
        32'h20080005, 32'h2009000A, 32'h01095020, 32'h01285822,
        32'hAC0A0000, 32'h8C0C0000, 32'h08000000, 32'h00000000
    };

    instruction_memory #(
        .DEPTH (64),
        .ADDR_W(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .instruction(instruction)
`ifdef IMEM_FAULT_EN
        ,
        .fault      (fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_wdata = data;
        tick();
        prog_we    = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        pc         = '0;

        read_check("powerup_w0", 32'h0, 32'h20080005);
        read_check("powerup_w6", 32'h18, 32'h08000000);

        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("sweep_w%0d", i), 32'(i * 4), image[i]);
        end

        read_check("misaligned_6", 32'h6, 32'h2009000A);
        read_check("misaligned_b", 32'hB, 32'h01095020);
        read_check("oob_depth", 32'h100, 32'h0);
        read_check("oob_top", 32'hFFFF_FFFC, 32'h0);
`ifdef IMEM_FAULT_EN
        pc = 32'h6;   #1; check("fault_misaligned", {31'b0, fault}, 32'h1);
        pc = 32'h100; #1; check("fault_oob", {31'b0, fault}, 32'h1);
        pc = 32'h8;   #1; check("fault_clear", {31'b0, fault}, 32'h0);
        pc = 32'hFC;  #1; check("fault_last_word", {31'b0, fault}, 32'h0);
`endif

        // Read-during-write: old word until the edge, new word after.
        pc         = 32'h40;
        prog_we    = 1'b1;
        prog_addr  = 32'h40;
        prog_wdata = 32'h012A4024;
        #1;
        check("pre_write_0x40", instruction, 32'h0);
        tick();
        prog_we = 1'b0;
        check("post_write_0x40", instruction, 32'h012A4024);

        write_word(32'h47, 32'hCAFE0001);
        read_check("misaligned_write", 32'h44, 32'hCAFE0001);
        write_word(32'hFC, 32'h5A5A5A5A);
        read_check("last_word_write", 32'hFC, 32'h5A5A5A5A);

        write_word(32'h0, 32'hDEADBEEF);
        read_check("overwrite_w0", 32'h0, 32'hDEADBEEF);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_check("reset_restore_w0", 32'h0, 32'h20080005);
        read_check("reset_clear_0x40", 32'h40, 32'h0);
        read_check("reset_clear_0x44", 32'h44, 32'h0);
        read_check("reset_clear_0xfc", 32'hFC, 32'h0);

        reset = 1'b1;
        write_word(32'h8, 32'hFFFFFFFF);
        reset = 1'b0;
        read_check("collision_w2", 32'h8, 32'h01095020);

        reset = 1'b1;
        write_word(32'h10, 32'h12345678);
        write_word(32'h14, 32'h87654321);
        write_word(32'h50, 32'h0BADF00D);
        reset = 1'b0;
        read_check("held_reset_w4", 32'h10, 32'hAC0A0000);
        read_check("held_reset_w5", 32'h14, 32'h8C0C0000);
        read_check("held_reset_0x50", 32'h50, 32'h0);

        write_word(32'h100, 32'h11111111);
        write_word(32'h8000_0000, 32'h22222222);
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("oob_write_w%0d", i), 32'(i * 4), image[i]);
        end
        read_check("oob_write_0x100", 32'h100, 32'h0);
        read_check("oob_write_0xfc", 32'hFC, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
